// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path.
// Used by result_bcd_converter and bcd_add3.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int CONV_DATA_W = 8;
    localparam int CONV_ITERS  = CONV_DATA_W + 1;

    localparam bcd_digit_t ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import calc_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    // Pre-shift correction of one BCD digit
    assign digit_o = (digit_i >= ADD3_THRESH) ? bcd_digit_t'(digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// Optional feature macro: SIGNED_RESULT_EN (two's complement sum, sign on neg).
module result_bcd_converter
    import calc_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     sum,
    input  logic                  carry,
    input  logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  err
);

    localparam int VAL_W = DATA_W + 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(VAL_W - 1);

    conv_state_t        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [VAL_W-1:0]   val_q;
    logic [BCD_W-1:0]   acc_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               neg_q;
    logic               err_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_d;
    logic [VAL_W-1:0]   val_d;
    logic [VAL_W-1:0]   load_val;
    logic               load_neg;

`ifdef SIGNED_RESULT_EN
    logic [DATA_W-1:0]  mag;
    logic               unused_carry;

    // Signed operand: convert the magnitude, report the sign separately
    always_comb begin
        unused_carry = carry;
        load_neg     = sum[DATA_W-1];
        mag          = load_neg ? DATA_W'(~sum + 1'b1) : sum;
        load_val     = {1'b0, mag};
    end
`else
    // Unsigned operand: carry is the ninth bit of the value
    always_comb begin
        load_neg = 1'b0;
        load_val = {carry, sum};
    end
`endif

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .digit_i (acc_q[4*g +: 4]),
                .digit_o (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // One double-dabble step: corrected digits and value shift left as one word
    always_comb begin
        acc_d = {acc_adj[BCD_W-2:0], val_q[VAL_W-1]};
        val_d = {val_q[VAL_W-2:0], 1'b0};
    end

    // Converter FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            val_q       <= '0;
            acc_q       <= '0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        val_q      <= load_val;
                        acc_q      <= '0;
                        neg_q      <= load_neg;
                        err_q      <= overflow;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    val_q <= val_d;
                    if (cnt_q == LAST_ITER) begin
                        bcd_q       <= acc_d;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign neg       = neg_q;
    assign err       = err_q;

endmodule
